twiddle_rom: RTL and testbench

- Downstream consumer of the twiddle exponent generator in the in-place radix-2 FFT.
- Maps exponent k (0..N/2-1) to the complex twiddle factor W_N^k = cos(2πk/N) - j·sin(2πk/N), in signed fixed point.
- Output feeds the butterfly multiplier.
- Stores only a quarter-wave cosine table and uses symmetry, pipelined over 2 register stages, with a stall input.

---
 rtl/twiddle_rom_if.sv | 31 +++
 rtl/twiddle_rom.sv | 115 +++++++++++
 tb/tb_twiddle_rom.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_rom_if.sv
// Twiddle ROM request/response bundle.
// Exponent in with stall; twiddle factor out.
interface twiddle_rom_if #(
  parameter int R = 5,
  parameter int W = 16
);
  logic                i_valid;
  logic [R-2:0]        i_exponent;
  logic                i_stall;
  logic                o_valid;
  logic signed [W-1:0] o_wr;
  logic signed [W-1:0] o_wi;

  modport master (
    output i_valid,
    output i_exponent,
    output i_stall,
    input  o_valid,
    input  o_wr,
    input  o_wi
  );

  modport slave (
    input  i_valid,
    input  i_exponent,
    input  i_stall,
    output o_valid,
    output o_wr,
    output o_wi
  );
endinterface

// File: rtl/twiddle_rom.sv
// Radix-2 FFT twiddle ROM: quarter-wave cosine table
// with symmetry folding, two register stages, stall.
module twiddle_rom #(
  parameter int R = 5,
  parameter int N = 32,
  parameter int W = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  twiddle_rom_if.slave bus
);
  localparam int  Q  = N / 4;
  localparam int  AW = R - 1;
  localparam real PI = 3.14159265358979323846;

  typedef logic signed [W-1:0] tbl_t [0:Q];

  // cos(x) by Taylor series, x in [0, pi/2]; round half up (values >= 0)
  function automatic tbl_t build_tbl();
    tbl_t t;
    real  x;
    real  term;
    real  sum;
    for (int m = 0; m <= Q; m++) begin
      x    = 2.0 * PI * m / N;
      sum  = 1.0;
      term = 1.0;
      for (int n = 1; n <= 20; n++) begin
        term = -term * x * x / ((2 * n - 1) * (2 * n));
        sum  = sum + term;
      end
      t[m] = W'($rtoi(sum * (2.0 ** (W - 2)) + 0.5));
    end
    t[0] = W'(1 << (W - 2));
    t[Q] = '0;
    return t;
  endfunction

  localparam tbl_t TBL = build_tbl();

  localparam logic [AW-1:0] QA = AW'(Q);
  localparam logic [AW-1:0] HA = AW'(N / 2);

  logic [AW-1:0] k;
  logic [AW-1:0] ar_d;
  logic [AW-1:0] ai_d;
  logic          nr_d;
  logic          ni_d;

  assign k = bus.i_exponent;

  always_comb begin
    ar_d = '0;
    ai_d = '0;
    nr_d = 1'b0;
    ni_d = 1'b0;
    unique case (1'b1)
      (k <= QA): begin
        ar_d = k;
        nr_d = 1'b0;
        ai_d = QA - k;
        ni_d = 1'b1;
      end
      default: begin
        // HA wraps to 0 in AW bits: still yields N/2-k
        ar_d = HA - k;
        nr_d = 1'b1;
        ai_d = k - QA;
        ni_d = 1'b1;
      end
    endcase
  end

  logic          s1_valid;
  logic [AW-1:0] s1_ar;
  logic [AW-1:0] s1_ai;
  logic          s1_nr;
  logic          s1_ni;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_nr    <= 1'b0;
      s1_ni    <= 1'b0;
    end else if (!bus.i_stall) begin
      s1_valid <= bus.i_valid;
      s1_ar    <= ar_d;
      s1_ai    <= ai_d;
      s1_nr    <= nr_d;
      s1_ni    <= ni_d;
    end
  end

  logic signed [W-1:0] tr;
  logic signed [W-1:0] ti;

  assign tr = TBL[s1_ar];
  assign ti = TBL[s1_ai];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_valid <= 1'b0;
      bus.o_wr    <= '0;
      bus.o_wi    <= '0;
    end else if (!bus.i_stall) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.o_wr <= s1_nr ? -tr : tr;
        bus.o_wi <= s1_ni ? -ti : ti;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_rom.sv
// Directed bench for twiddle_rom, N=32, W=16.
module tb_twiddle_rom;
  localparam int R = 5;
  localparam int N = 32;
  localparam int W = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  twiddle_rom_if #(.R(R), .W(W)) bus ();

  twiddle_rom #(.R(R), .N(N), .W(W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_exponent = '0;
    bus.i_stall = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp += 3;
      if (bus.o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_valid c=%0d got %b want 0", c, bus.o_valid);
      end
      if (bus.o_wr !== 16'sd0) begin
        n_bad++;
        $display("FAIL reset_wr c=%0d got %0d want 0", c, bus.o_wr);
      end
      if (bus.o_wi !== 16'sd0) begin
        n_bad++;
        $display("FAIL reset_wi c=%0d got %0d want 0", c, bus.o_wi);
      end
    end
  endtask

  task automatic test_single(input int k, input int er, input int ei);
    bus.i_valid = 1'b1;
    bus.i_exponent = 4'(k);
    step();
    bus.i_valid = 1'b0;
    n_cmp++;
    if (bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early k=%0d got %b want 0", k, bus.o_valid);
    end
    step();
    n_cmp += 3;
    if (bus.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_valid k=%0d got %b want 1", k, bus.o_valid);
    end
    if (bus.o_wr !== 16'(er)) begin
      n_bad++;
      $display("FAIL single_wr k=%0d got %0d want %0d", k, bus.o_wr, er);
    end
    if (bus.o_wi !== 16'(ei)) begin
      n_bad++;
      $display("FAIL single_wi k=%0d got %0d want %0d", k, bus.o_wi, ei);
    end
    step();
    n_cmp += 3;
    if (bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drop k=%0d got %b want 0", k, bus.o_valid);
    end
    if (bus.o_wr !== 16'(er) || bus.o_wi !== 16'(ei)) begin
      n_bad++;
      $display("FAIL single_hold k=%0d got (%0d,%0d) want (%0d,%0d)",
               k, bus.o_wr, bus.o_wi, er, ei);
    end
  endtask

  task automatic test_back_to_back();
    bus.i_valid = 1'b1;
    bus.i_exponent = 4'd12;
    step();
    bus.i_exponent = 4'd15;
    step();
    bus.i_valid = 1'b0;
    n_cmp += 2;
    if (bus.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_v12 got %b want 1", bus.o_valid);
    end
    if (bus.o_wr !== -16'sd11585 || bus.o_wi !== -16'sd11585) begin
      n_bad++;
      $display("FAIL b2b_k12 got (%0d,%0d) want (-11585,-11585)",
               bus.o_wr, bus.o_wi);
    end
    step();
    n_cmp += 2;
    if (bus.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_v15 got %b want 1", bus.o_valid);
    end
    if (bus.o_wr !== -16'sd16069 || bus.o_wi !== -16'sd3196) begin
      n_bad++;
      $display("FAIL b2b_k15 got (%0d,%0d) want (-16069,-3196)",
               bus.o_wr, bus.o_wi);
    end
    step();
    n_cmp++;
    if (bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_sweep();
    int nv = 0;
    for (int c = 0; c <= 16; c++) begin
      bus.i_valid = (c < 16);
      bus.i_exponent = 4'(c);
      step();
      if (c >= 1) begin
        int j = c - 1;
        logic signed [W-1:0] ew;
        logic signed [W-1:0] ei;
        ew = 16'(rnd($cos(2.0 * PI * j / N) * 16384.0));
        ei = 16'(rnd(-$sin(2.0 * PI * j / N) * 16384.0));
        if (bus.o_valid === 1'b1) nv++;
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_wr !== ew || bus.o_wi !== ei) begin
          n_bad++;
          $display("FAIL sweep k=%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                   j, bus.o_valid, bus.o_wr, bus.o_wi, ew, ei);
        end
      end
    end
    bus.i_valid = 1'b0;
    step();
    n_cmp += 2;
    if (bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_end got %b want 0", bus.o_valid);
    end
    if (nv != 16) begin
      n_bad++;
      $display("FAIL sweep_count got %0d want 16", nv);
    end
  endtask

  task automatic test_stall();
    int nv = 0;
    bus.i_valid = 1'b1;
    bus.i_exponent = 4'd4;
    step();
    bus.i_stall = 1'b1;
    bus.i_exponent = 4'd9;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (bus.o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold c=%0d got %b want 0", c, bus.o_valid);
      end
    end
    bus.i_stall = 1'b0;
    bus.i_valid = 1'b0;
    step();
    n_cmp++;
    if (bus.o_valid !== 1'b1 || bus.o_wr !== 16'sd11585 ||
        bus.o_wi !== -16'sd11585) begin
      n_bad++;
      $display("FAIL stall_out got v=%b (%0d,%0d) want v=1 (11585,-11585)",
               bus.o_valid, bus.o_wr, bus.o_wi);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.o_valid === 1'b1) nv++;
    end
    n_cmp += 2;
    if (nv != 0) begin
      n_bad++;
      $display("FAIL stall_extra got %0d extra valids want 0", nv);
    end
    if (bus.o_wr !== 16'sd11585 || bus.o_wi !== -16'sd11585) begin
      n_bad++;
      $display("FAIL stall_k9 got (%0d,%0d) want (11585,-11585)",
               bus.o_wr, bus.o_wi);
    end
  endtask

  task automatic test_reset_stall();
    int nv = 0;
    bus.i_valid = 1'b1;
    bus.i_exponent = 4'd8;
    step();
    bus.i_valid = 1'b0;
    rst = 1'b1;
    bus.i_stall = 1'b1;
    step();
    n_cmp++;
    if (bus.o_valid !== 1'b0 || bus.o_wr !== 16'sd0 || bus.o_wi !== 16'sd0) begin
      n_bad++;
      $display("FAIL rststall got v=%b (%0d,%0d) want v=0 (0,0)",
               bus.o_valid, bus.o_wr, bus.o_wi);
    end
    rst = 1'b0;
    bus.i_stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.o_valid === 1'b1) nv++;
    end
    n_cmp += 2;
    if (nv != 0) begin
      n_bad++;
      $display("FAIL rststall_ghost got %0d valids want 0", nv);
    end
    if (bus.o_wr !== 16'sd0 || bus.o_wi !== 16'sd0) begin
      n_bad++;
      $display("FAIL rststall_out got (%0d,%0d) want (0,0)",
               bus.o_wr, bus.o_wi);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_exponent = '0;
    bus.i_stall = 1'b0;
    test_reset();
    test_single(0, 16384, 0);
    test_single(8, 0, -16384);
    test_single(4, 11585, -11585);
    test_single(1, 16069, -3196);
    test_back_to_back();
    test_sweep();
    test_stall();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
